mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU address, store data and funct3, and runs a req/ack transaction to data memory.
- Stores get byte-lane enables; loads return sign- or zero-extended data.
- Stalls the pipeline while a transaction is outstanding and flags bus timeouts.

Parameters:
- ACK_TIMEOUT, 255: cycles in WAIT without dmem_ack before a bus error is declared. Range 1..65535.
- TO_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  execute-stage result valid this cycle
- MemRead  in  1  load instruction
- MemWrite  in  1  store instruction
- funct3  in  3  access size/sign (instruction[14:12])
- alu_result  in  32  effective byte address
- mem_write_data  in  32  store data (rs2)
- stall  out  1  hold upstream stages
- done  out  1  one-cycle pulse: access complete
- load_data  out  32  extended load result, valid while done=1
- bus_error  out  1  one-cycle pulse with done on timeout
- misalign  out  1  misaligned access flag (MISALIGN_TRAP_EN only; tied 0 otherwise)
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory completion
- dmem_rdata  in  32  memory read word, sampled on ack

Behaviour:
- Reset:
  - state=IDLE.
  - All registered outputs 0: done, load_data, bus_error, misalign, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - Timeout counter 0.
- Access start:
  - An access is mem_valid && (MemRead||MemWrite).
  - MemWrite has priority if both are set.
  - mem_valid with neither set: no stall, no done, no memory traffic.
- FSM IDLE:
  - stall = access (combinational).
  - On an access edge: latch address, data, funct3 and type; drive dmem_req=1 with addr/be/wdata/we registered; go WAIT; clear counter.
- FSM WAIT:
  - stall=1; dmem_req held 1 and all dmem_* stable.
  - dmem_ack=1: capture rdata, drop req, go RESP.
  - Else counter++; if counter==ACK_TIMEOUT-1: drop req, set error, go RESP.
  - Ack in the same cycle as expiry: ack wins, no error.
- FSM RESP:
  - done=1 and stall=0 for exactly one cycle, then IDLE.
  - bus_error=1 if timed out.
  - load_data = 0 for stores and for timeouts.
  - A new access may be presented in the cycle after RESP.
- Latency: 0-wait memory (ack in first WAIT cycle) gives request→done in 3 cycles (IDLE edge, WAIT, RESP).
- Stores, byte lanes by address[1:0]:
  - SB (000): be=1<<a[1:0], wdata={4{b}}.
  - SH (001): be=a[1]?1100:0011, wdata={2{h}}.
  - SW (010) and other codes: be=1111.
- Loads:
  - dmem_be=1111; byte/half selected by a[1:0] from the captured word.
  - LB 000 sign-extended, LBU 100 zero-extended, LH 001 sign-extended, LHU 101 zero-extended.
  - LW 010, and 011/110/111, return the full word.
- Misaligned without the macro: low address bits are ignored for half/word lane selection (half uses a[1], word uses none).
- dmem_ack in IDLE or RESP: ignored.
- rst in any state: next edge returns to IDLE with req=0 and outputs cleared; a late ack is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - An access with (half && a[0]) or (word && a[1:0]!=0) issues no memory request.
  - FSM goes IDLE→RESP directly: misalign=1 and done=1 for one cycle, load_data=0, nothing written.
- Undefined: misalign port tied 0; forced-alignment behaviour above.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack after 2 WAIT cycles -> dmem_addr=0x100, be=1111, we=1; stall high 3 cycles; done pulse once; nothing else written.
- LB addr 0x203, rdata 0x80FF_1234 -> be=1111; load_data=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr 0x202, rdata 0x8001_0000 -> 0xFFFF8001. SB addr 0x101, data 0x000000AB -> be=0010, wdata=0xABABABAB.
- ACK_TIMEOUT=4, no ack -> req high exactly 4 cycles; done+bus_error pulse together; load_data=0. Ack on the 4th cycle -> no error.
- rst asserted in WAIT, then ack one cycle later -> req=0 and state IDLE after the edge; ack ignored, no done.
- MISALIGN_TRAP_EN, LW addr 0x102 -> dmem_req never asserts; misalign=done=1 one cycle later. Without the macro -> dmem_addr=0x100, full word returned.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack data-memory transaction with store byte lanes and load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with misalign=1 and no bus traffic.
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_write_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_error,
    output logic        misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            bus_error_q, bus_error_d;
    logic            misalign_q, misalign_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      alo_q, alo_d;
    logic [2:0]      f3_q, f3_d;

    logic        access, misal, timeout;
    logic [1:0]  alo;
    logic [3:0]  be_st;
    logic [31:0] wdata_st, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign access  = mem_valid && (MemRead || MemWrite);
    assign alo     = alu_result[1:0];
    assign timeout = (state_q == S_WAIT) && !dmem_ack && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    logic is_half, is_word;
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = funct3[1] || (funct3[1:0] == 2'b11);
    assign misal   = access && ((is_half && alo[0]) || (is_word && alo != 2'b00));
`else
    assign misal   = 1'b0;
`endif

    // Store lanes: sub-word data replicated across the word so any enabled lane sees it.
    always_comb begin
        be_st    = 4'b1111;
        wdata_st = mem_write_data;
        case (funct3[1:0])
            2'b00: begin
                be_st    = 4'b0001 << alo;
                wdata_st = {4{mem_write_data[7:0]}};
            end
            2'b01: begin
                be_st    = alo[1] ? 4'b1100 : 4'b0011;
                wdata_st = {2{mem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alo_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access) state_d = misal ? S_RESP : S_WAIT;
            S_WAIT:  if (dmem_ack || timeout) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        load_data_d = 32'b0;
        bus_error_d = 1'b0;
        misalign_d  = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        alo_d       = alo_q;
        f3_d        = f3_q;
        case (state_q)
            S_IDLE: begin
                stall = access;
                if (access && misal) begin
                    done_d     = 1'b1;
                    misalign_d = 1'b1;
                end else if (access) begin
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {alu_result[31:2], 2'b00};
                    be_d    = MemWrite ? be_st : 4'b1111;
                    wdata_d = wdata_st;
                    alo_d   = alo;
                    f3_d    = funct3;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    req_d       = 1'b0;
                    done_d      = 1'b1;
                    load_data_d = we_q ? 32'b0 : ld_ext;
                end else if (timeout) begin
                    req_d       = 1'b0;
                    done_d      = 1'b1;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            load_data_q <= 32'b0;
            bus_error_q <= 1'b0;
            misalign_q  <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'b0;
            be_q        <= 4'b0;
            wdata_q     <= 32'b0;
            alo_q       <= 2'b0;
            f3_q        <= 3'b0;
        end else begin
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
            misalign_q  <= misalign_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            alo_q       <= alo_d;
            f3_q        <= f3_d;
        end
    end

    assign done       = done_q;
    assign load_data  = load_data_q;
    assign bus_error  = bus_error_q;
    assign misalign   = misalign_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected responses queued at issue, checked on done.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] alu_result, mem_write_data;
    logic        stall, done, bus_error, misalign;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    typedef struct {
        logic [31:0] ld;
        logic        berr;
        logic        mis;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_access_stage #(.ACK_TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .alu_result(alu_result), .mem_write_data(mem_write_data),
        .stall(stall), .done(done), .load_data(load_data),
        .bus_error(bus_error), .misalign(misalign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ld, input logic berr, input logic mis,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic we, input logic [31:0] wd);
        exp_t e;
        e.ld = ld; e.berr = berr; e.mis = mis; e.addr = addr; e.be = be; e.we = we; e.wd = wd;
        return e;
    endfunction

    // Reference model, written per byte lane.
    function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (!wr)                    r[i] = 1'b1;
            else if (f3[1:0] == 2'b00)  r[i] = (2'(i) == a);
            else if (f3[1:0] == 2'b01)  r[i] = (1'(i / 2) == a[1]);
            else                        r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            if (f3[1:0] == 2'b00)      r[8*i +: 8] = d[7:0];
            else if (f3[1:0] == 2'b01) r[8*i +: 8] = d[8*(i%2) +: 8];
            else                       r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] s;
        int sh;
        sh = (f3[1:0] == 2'b00) ? 8 * int'(a) : (f3[1:0] == 2'b01) ? 16 * int'(a[1]) : 0;
        s  = w >> sh;
        case (f3)
            3'b000:  return s[7]  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            3'b100:  return s & 32'h0000_00FF;
            3'b001:  return s[15] ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            3'b101:  return s & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // ack_dly: WAIT cycle (1-based) in which ack is returned; <=0 or >TO means never.
    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int ack_dly, input exp_t e);
        int   r, reqc, stc;
        bit   fin;
        exp_t x, f;
        r = e.mis ? 0 : ((ack_dly >= 1 && ack_dly <= TO) ? ack_dly : TO);
        sb.push_back(e);
        @(negedge clk);
        mem_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3;
        alu_result = a; mem_write_data = wd;
        #1;
        chk("stall_issue", 32'(stall), 32'd1);
        stc = 1; reqc = 0; fin = 0;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (done) begin
                x = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(r + 1));
                chk("req_cycles", 32'(reqc), 32'(r));
                chk("load_data", load_data, x.ld);
                chk("bus_error", 32'(bus_error), 32'(x.berr));
                chk("misalign", 32'(misalign), 32'(x.mis));
                chk("stall_resp", 32'(stall), 32'd0);
                fin = 1;
                mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
            end else begin
                if (dmem_req) begin
                    reqc++;
                    if (reqc == 1) begin
                        f = sb[0];
                        chk("dmem_addr", dmem_addr, f.addr);
                        chk("dmem_be", 32'(dmem_be), 32'(f.be));
                        chk("dmem_we", 32'(dmem_we), 32'(f.we));
                        if (f.we) chk("dmem_wdata", dmem_wdata, f.wd);
                    end
                    if (reqc == ack_dly) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = rword;
                    end
                end
                if (stall) stc++;
            end
        end
        if (!fin) begin
            chk("done_never_seen", 32'd0, 32'd1);
            void'(sb.pop_front());
            mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        end
        chk("stall_cycles", 32'(stc), 32'(r + 1));
        @(negedge clk);
        chk("idle_req", 32'(dmem_req), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        logic [31:0] rv, rw, rd32;
        logic [1:0]  lo;
        logic [2:0]  f3;
        logic        wr;
        int          dly;

        rst = 1'b1; mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0;
        alu_result = 32'b0; mem_write_data = 32'b0; dmem_ack = 1'b0; dmem_rdata = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        xact(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2,
             mk(32'h0, 0, 0, 32'h100, 4'b1111, 1, 32'hDEADBEEF));
        xact(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 1,
             mk(32'hFFFF_FF80, 0, 0, 32'h200, 4'b1111, 0, 32'h0));
        xact(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 1,
             mk(32'h0000_0080, 0, 0, 32'h200, 4'b1111, 0, 32'h0));
        xact(1, 0, 3'b001, 32'h202, 32'h0, 32'h8001_0000, 3,
             mk(32'hFFFF_8001, 0, 0, 32'h200, 4'b1111, 0, 32'h0));
        xact(0, 1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 1,
             mk(32'h0, 0, 0, 32'h100, 4'b0010, 1, 32'hABAB_ABAB));
        xact(0, 1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0, 1,
             mk(32'h0, 0, 0, 32'h100, 4'b1100, 1, 32'hBEEF_BEEF));
        xact(1, 0, 3'b101, 32'h200, 32'h0, 32'h1234_8001, 2,
             mk(32'h0000_8001, 0, 0, 32'h200, 4'b1111, 0, 32'h0));
        xact(1, 0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, 0,
             mk(32'h0, 1, 0, 32'h400, 4'b1111, 0, 32'h0));
        xact(1, 0, 3'b010, 32'h404, 32'h0, 32'h1234_5678, TO,
             mk(32'h1234_5678, 0, 0, 32'h404, 4'b1111, 0, 32'h0));
        xact(0, 1, 3'b010, 32'h408, 32'hFFFF_0000, 32'h0, 0,
             mk(32'h0, 1, 0, 32'h408, 4'b1111, 1, 32'hFFFF_0000));
`ifdef MISALIGN_TRAP_EN
        xact(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 1,
             mk(32'h0, 0, 1, 32'h0, 4'b0, 0, 32'h0));
`else
        xact(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 1,
             mk(32'hCAFE_F00D, 0, 0, 32'h100, 4'b1111, 0, 32'h0));
`endif

        // mem_valid with neither load nor store: no stall, no traffic.
        @(negedge clk);
        mem_valid = 1'b1;
        #1 chk("nop_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("nop_req", 32'(dmem_req), 32'd0);
        chk("nop_done", 32'(done), 32'd0);
        mem_valid = 1'b0;

        // Reset in WAIT, then a late ack that must be ignored.
        @(negedge clk);
        mem_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; alu_result = 32'h300;
        @(negedge clk);
        chk("rstw_req_up", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_done", 32'(done), 32'd0);
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_done", 32'(done), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk("late_ack_done2", 32'(done), 32'd0);
        chk("late_ack_ld", load_data, 32'd0);

        // Random naturally aligned traffic against the lane model.
        for (int k = 0; k < 16; k++) begin
            rv   = $urandom();
            rw   = $urandom();
            rd32 = $urandom();
            wr   = rv[0];
            case (rv[3:1] % 5)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = wr ? 3'b010 : 3'b100;
                default: f3 = wr ? 3'b000 : 3'b101;
            endcase
            lo  = (f3[1:0] == 2'b00) ? rv[5:4] : (f3[1:0] == 2'b01) ? {rv[5], 1'b0} : 2'b00;
            dly = $urandom_range(1, TO);
            xact(!wr, wr, f3, {rv[31:8], 6'b0, lo}, rw, rd32, dly,
                 mk(wr ? 32'h0 : m_ld(f3, lo, rd32), 0, 0, {rv[31:8], 8'h00},
                    m_be(wr, f3, lo), wr, m_wd(f3, rw)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
